// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the zero-initialised single-port SRAM controller.
package sram_ctrl_pkg;

  localparam int unsigned SETS_DEFAULT  = 256;
  localparam int unsigned WIDTH_DEFAULT = 13;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } init_state_e;

endpackage

// File: rtl/sram_init_seq.sv
// Clear sequencer: walks every entry once after reset, then hands the port over.
//
// state | meaning
// INIT  | writing zero to entry `count`, one entry per cycle
// IDLE  | clear finished, port open to read/write requests
module sram_init_seq
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned SETS         = SETS_DEFAULT,
  parameter bit          SHOULD_RESET = 1'b1,
  localparam int unsigned AW          = $clog2(SETS)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          init_busy,
  output logic [AW-1:0] init_addr,
  output logic          init_done
);

  init_state_e   state, state_nxt;
  logic [AW-1:0] count, count_nxt;
  logic          count_last;

  assign count_last = (count == AW'(SETS - 1));

  // state and clear-address registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SHOULD_RESET ? INIT : IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // advance through the entries; counter parks on the last entry instead of wrapping
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (state == INIT) begin
      if (count_last) state_nxt = IDLE;
      else            count_nxt = count + 1'b1;
    end
  end

  assign init_busy = (state == INIT);
  assign init_addr = count;
  assign init_done = (state == IDLE);

endmodule

// File: rtl/sram_ctrl_256x13.sv
// Request-side controller for a single-port SRAM macro with registered read:
// clears the array after reset, arbitrates write-over-read, and returns held read data.
module sram_ctrl_256x13
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned SETS         = SETS_DEFAULT,
  parameter int unsigned WIDTH        = WIDTH_DEFAULT,
  parameter bit          SHOULD_RESET = 1'b1,
  parameter bit          HOLD_READ    = 1'b1,
  localparam int unsigned AW          = $clog2(SETS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             r_req_valid,
  output logic             r_req_ready,
  input  logic [AW-1:0]    r_req_setIdx,
  output logic             r_resp_valid,
  output logic [WIDTH-1:0] r_resp_data,
  input  logic             w_req_valid,
  output logic             w_req_ready,
  input  logic [AW-1:0]    w_req_setIdx,
  input  logic [WIDTH-1:0] w_req_data,
  output logic             init_done,
  output logic [AW-1:0]    sram_addr,
  output logic             sram_en,
  output logic             sram_wmode,
  output logic [WIDTH-1:0] sram_wdata,
  input  logic [WIDTH-1:0] sram_rdata
);

  logic          init_busy;
  logic          seq_done;
  logic [AW-1:0] init_addr;
  logic          port_open;
  logic          w_fire;
  logic          r_fire;
  logic          resp_pending;
  logic [WIDTH-1:0] hold_q;

  sram_init_seq #(
    .SETS         (SETS),
    .SHOULD_RESET (SHOULD_RESET)
  ) u_init_seq (
    .clock     (clock),
    .reset     (reset),
    .init_busy (init_busy),
    .init_addr (init_addr),
    .init_done (seq_done)
  );

  // reset is folded in so nothing reaches the macro or the requesters while it is held
  assign port_open   = seq_done & ~reset;
  assign init_done   = port_open;
  assign w_req_ready = port_open;
  assign r_req_ready = port_open & ~w_req_valid;
  assign w_fire      = w_req_valid & w_req_ready;
  assign r_fire      = r_req_valid & r_req_ready;

  // macro port mux: clear sequence, then write, then read
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = r_req_setIdx;
    sram_wdata = w_req_data;
    if (init_busy) begin
      sram_en    = ~reset;
      sram_wmode = 1'b1;
      sram_addr  = init_addr;
      sram_wdata = '0;
    end else if (w_fire) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = w_req_setIdx;
    end else if (r_fire) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b0;
      sram_addr  = r_req_setIdx;
    end
  end

  // response flag: macro data is valid the cycle after a read enable
  always_ff @(posedge clock or posedge reset) begin
    if (reset) resp_pending <= 1'b0;
    else       resp_pending <= r_fire;
  end

  // remember the last returned word so the output survives idle cycles and writes
  always_ff @(posedge clock or posedge reset) begin
    if (reset)             hold_q <= '0;
    else if (resp_pending) hold_q <= sram_rdata;
  end

  assign r_resp_valid = resp_pending;

  generate
    if (HOLD_READ) begin : g_hold
      assign r_resp_data = resp_pending ? sram_rdata : hold_q;
    end else begin : g_raw
      assign r_resp_data = sram_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_sram_ctrl_256x13.sv
// Scoreboard bench: behavioural macro plus an array reference of the stored contents.
module tb_sram_ctrl_256x13;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        r_req_valid, r_req_ready, r_resp_valid;
  logic [7:0]  r_req_setIdx;
  logic [12:0] r_resp_data;
  logic        w_req_valid, w_req_ready;
  logic [7:0]  w_req_setIdx;
  logic [12:0] w_req_data;
  logic        init_done;
  logic [7:0]  sram_addr;
  logic        sram_en, sram_wmode;
  logic [12:0] sram_wdata, sram_rdata;

  logic [12:0] mem     [256];
  logic [12:0] ref_mem [256];
  logic [12:0] exp_q [$];
  logic [12:0] last_data;
  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sram_ctrl_256x13 dut (
    .clock        (clock),
    .reset        (reset),
    .r_req_valid  (r_req_valid),
    .r_req_ready  (r_req_ready),
    .r_req_setIdx (r_req_setIdx),
    .r_resp_valid (r_resp_valid),
    .r_resp_data  (r_resp_data),
    .w_req_valid  (w_req_valid),
    .w_req_ready  (w_req_ready),
    .w_req_setIdx (w_req_setIdx),
    .w_req_data   (w_req_data),
    .init_done    (init_done),
    .sram_addr    (sram_addr),
    .sram_en      (sram_en),
    .sram_wmode   (sram_wmode),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  // single-port macro with one-cycle registered read
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) mem[sram_addr] <= sram_wdata;
      else            sram_rdata     <= mem[sram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: pop an expected word on every response, otherwise data must hold
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      if (r_resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected actual=valid required=no_response data=%0h", r_resp_data);
        end else begin
          last_data = exp_q.pop_front();
          chk("resp_data", r_resp_data, last_data);
        end
      end else begin
        chk("hold_data", r_resp_data, last_data);
      end
    end
  end

  // one request cycle: drive, check handshake and macro port, update reference
  task automatic cycle(input logic wv, input logic [7:0] wa, input logic [12:0] wd,
                       input logic rv, input logic [7:0] ra);
    w_req_valid  = wv;
    w_req_setIdx = wa;
    w_req_data   = wd;
    r_req_valid  = rv;
    r_req_setIdx = ra;
    #1;
    chk("w_ready", w_req_ready, 1);
    chk("r_ready", r_req_ready, !wv);
    if (wv) begin
      chk("wr_port", {sram_en, sram_wmode, sram_addr, sram_wdata}, {1'b1, 1'b1, wa, wd});
      ref_mem[wa] = wd;
    end else if (rv) begin
      chk("rd_port", {sram_en, sram_wmode, sram_addr}, {1'b1, 1'b0, ra});
      exp_q.push_back(ref_mem[ra]);
    end else begin
      chk("idle_en", sram_en, 0);
    end
    @(negedge clock);
  endtask

  // clear phase: n cycles of zero writes to ascending addresses, requests ignored
  task automatic run_init(input int n);
    for (int k = 0; k < n; k++) begin
      #1;
      chk("init_done_low", init_done, 0);
      chk("init_readies", {w_req_ready, r_req_ready}, 0);
      chk("init_port", {sram_en, sram_wmode, sram_wdata}, {1'b1, 1'b1, 13'h0});
      chk("init_addr", sram_addr, k);
      @(negedge clock);
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = 13'h0;
  endtask

  initial begin
    logic        wv, rv;
    logic [7:0]  wa, ra;
    logic [12:0] wd;
    for (int i = 0; i < 256; i++) mem[i] = 13'($urandom);
    sram_rdata   = 13'($urandom);
    last_data    = 13'h0;
    w_req_valid  = 1'b1;
    w_req_setIdx = 8'h33;
    w_req_data   = 13'h0AA;
    r_req_valid  = 1'b1;
    r_req_setIdx = 8'h33;
    clear_ref();

    repeat (3) @(negedge clock);
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_readies", {w_req_ready, r_req_ready}, 0);
    chk("rst_resp_valid", r_resp_valid, 0);
    chk("rst_resp_data", r_resp_data, 0);
    chk("rst_sram_en", sram_en, 0);

    @(negedge clock);
    reset = 1'b0;
    run_init(256);
    #1;
    chk("init_done_rise", init_done, 1);

    // requests held through the clear fire on the first open cycle
    cycle(1'b1, 8'h33, 13'h0AA, 1'b1, 8'h33);
    for (int i = 0; i < 256; i++) cycle(1'b0, 8'h0, 13'h0, 1'b1, 8'(i));

    cycle(1'b1, 8'h05, 13'h1ABC, 1'b0, 8'h0);
    cycle(1'b0, 8'h0, 13'h0, 1'b1, 8'h05);
    cycle(1'b1, 8'h10, 13'h0F0, 1'b1, 8'h10);
    cycle(1'b0, 8'h0, 13'h0, 1'b1, 8'h10);
    cycle(1'b0, 8'h0, 13'h0, 1'b1, 8'h05);
    repeat (10) cycle(1'b0, 8'h0, 13'h0, 1'b0, 8'h0);
    cycle(1'b1, 8'h05, 13'h0001, 1'b0, 8'h0);
    repeat (3) cycle(1'b0, 8'h0, 13'h0, 1'b0, 8'h0);

    repeat (400) begin
      wv = ($urandom_range(0, 2) == 0);
      rv = $urandom_range(0, 1) != 0;
      wa = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      wd = 13'($urandom);
      cycle(wv, wa, wd, rv, ra);
    end
    repeat (3) cycle(1'b0, 8'h0, 13'h0, 1'b0, 8'h0);
    chk("queue_drained", exp_q.size(), 0);

    // reset during the clear restarts it from entry 0
    reset = 1'b1;
    last_data = 13'h0;
    w_req_valid = 1'b1;
    r_req_valid = 1'b1;
    #1;
    chk("rst2_sram_en", sram_en, 0);
    chk("rst2_resp_valid", r_resp_valid, 0);
    @(negedge clock);
    reset = 1'b0;
    clear_ref();
    run_init(100);
    reset = 1'b1;
    #1;
    chk("midclear_rst_en", sram_en, 0);
    chk("midclear_rst_done", init_done, 0);
    @(negedge clock);
    reset = 1'b0;
    run_init(256);
    #1;
    chk("init_done_rise2", init_done, 1);
    cycle(1'b0, 8'h0, 13'h0, 1'b1, 8'h05);
    cycle(1'b0, 8'h0, 13'h0, 1'b1, 8'h10);
    cycle(1'b0, 8'h0, 13'h0, 1'b1, 8'h33);
    cycle(1'b0, 8'h0, 13'h0, 1'b1, 8'hFF);
    repeat (3) cycle(1'b0, 8'h0, 13'h0, 1'b0, 8'h0);
    chk("queue_drained2", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
